// File: rtl/cmd_sequencer.sv
// Command sequencer: queues 16-bit commands and issues them one at a time to the
// transmitter, waiting for an 8'hA5 acknowledge. Define CMD_SEQ_RETRY_EN to resend on failure.
module cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter int TIMEOUT_CLKS = 1000000,
  parameter int RETRIES      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cmd,
  input  logic [15:0] wr_data,
  output logic        full,
  output logic        empty,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        clr_err,
  output logic [2:0]  dbg_state
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0] ACK_BYTE = 8'hA5;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT_CLKS < 2 || RETRIES < 0) begin : g_bad_params
    $error("cmd_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_SENT = 3'd2,
    S_WAIT_RESP = 3'd3,
    S_ERR       = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [15:0]    cmd_q, cmd_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;
  logic           done_q, done_d;

  logic push_ok, pop;
  logic in_wait, resp_accept, resp_ack, resp_nack;
  logic tmo_limit, timeout_hit, fail, retry_ok;

  // Queue status comes only from the registered count.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = wr_cmd && !full;
  assign pop     = (state_q == S_IDLE) && !empty && !err_q;

  assign in_wait     = (state_q == S_WAIT_SENT) || (state_q == S_WAIT_RESP);
  assign resp_accept = (state_q == S_WAIT_RESP) && resp_rdy;
  assign resp_ack    = resp_accept && (resp == ACK_BYTE);
  assign resp_nack   = resp_accept && (resp != ACK_BYTE);
  // The edge closing this cycle brings the counter to TIMEOUT_CLKS-1.
  assign tmo_limit   = (32'(tmo_q) + 32'd1) >= 32'(TIMEOUT_CLKS - 1);
  assign timeout_hit = in_wait && !resp_accept && tmo_limit;
  assign fail        = resp_nack || timeout_hit;

`ifdef CMD_SEQ_RETRY_EN
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
  logic [RW-1:0] retry_q, retry_d;

  assign retry_ok = (32'(retry_q) < 32'(RETRIES));

  always_comb begin
    retry_d = retry_q;
    if (pop) begin
      retry_d = '0;
    end else if (fail && retry_ok) begin
      retry_d = retry_q + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    cmd_d  = pop ? mem_q[rd_ptr_q] : cmd_q;
    done_d = resp_ack;
    err_d  = err_q;
    if (fail && !retry_ok) begin
      err_d = 1'b1;
    end else if ((state_q == S_ERR) && clr_err) begin
      err_d = 1'b0;
    end
    tmo_d = tmo_q;
    if (state_q == S_SEND) begin
      tmo_d = '0;
    end else if (in_wait) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (fail) begin
          state_d = retry_ok ? S_SEND : S_ERR;
        end else if (cmd_sent) begin
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (resp_ack) begin
          state_d = S_IDLE;
        end else if (fail) begin
          state_d = retry_ok ? S_SEND : S_ERR;
        end
      end
      S_ERR: begin
        if (clr_err) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    send_cmd  = (state_q == S_SEND);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  assign cmd  = cmd_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
